// File: rtl/common_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : common_pkg                                                    |
// | Purpose  : Project-wide shared constants.                                |
// | Contents : DEFAULT_D_W - default data flit width in bits.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package common_pkg;

  localparam int DEFAULT_D_W = 16;

endpackage : common_pkg
`default_nettype wire

// File: rtl/noc_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : noc_arb_pkg                                                   |
// | Purpose  : Types shared by the NoC arbiters.                             |
// | Contents : rr_state_e - packet-lock state of a round-robin arbiter.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package noc_arb_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } rr_state_e;

endpackage : noc_arb_pkg
`default_nettype wire

// File: rtl/generic_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : generic_mux                                                   |
// | Purpose  : N:1 combinational multiplexer of W-bit words.                 |
// | Ports    : i_data [N-1:0][W-1:0] - input words                           |
// |            i_sel  [L-1:0]        - select index                          |
// |            o_data [W-1:0]        - selected word (0 if i_sel >= N)       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module generic_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0][W-1:0]    i_data,
  input  logic [$clog2(N)-1:0]   i_sel,
  output logic [W-1:0]           o_data
);

  localparam int L = $clog2(N);

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == L'(k)) begin
        o_data = i_data[k];
      end
    end
  end

endmodule : generic_mux
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_priority_pick                                              |
// | Purpose  : Combinational round-robin pick: first requester found when    |
// |            searching i_ptr+1, i_ptr+2, ... modulo N.                     |
// | Ports    : i_ptr         [L-1:0] - index of the most recent winner       |
// |            i_req         [N-1:0] - request vector                        |
// |            o_grant_valid         - at least one request present          |
// |            o_grant_idx   [L-1:0] - index of the chosen requester         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [$clog2(N)-1:0] i_ptr,
  input  logic [N-1:0]         i_req,
  output logic                 o_grant_valid,
  output logic [$clog2(N)-1:0] o_grant_idx
);

  localparam int L = $clog2(N);

  int w_idx;

  // Walk the search order backwards so the last hit written is the
  // requester closest to i_ptr+1, i.e. the highest-priority one.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = 0;
    for (int i = N; i >= 1; i--) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = L'(w_idx);
      end
    end
  end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux4_rr_arbiter                                               |
// | Purpose  : Round-robin arbiter with packet locking sharing one N:1 data  |
// |            mux, followed by a single-entry registered output stage.      |
// | Ports    : clk, rst_n (async, active low)                                |
// |            i_valid/i_data/i_last [N] - requester flits                   |
// |            i_ready [N]               - per-requester accept (one-hot0)   |
// |            o_valid/o_data/o_last/o_src - registered output flit          |
// |            o_ready                   - downstream accept                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mux4_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = common_pkg::DEFAULT_D_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         i_valid,
  input  logic [N-1:0][W-1:0]  i_data,
  input  logic [N-1:0]         i_last,
  output logic [N-1:0]         i_ready,
  output logic                 o_valid,
  output logic [W-1:0]         o_data,
  output logic                 o_last,
  output logic [$clog2(N)-1:0] o_src,
  input  logic                 o_ready
);

  localparam int L = $clog2(N);

  rr_state_e         r_state;
  logic [L-1:0]      r_ptr;
  logic [L-1:0]      r_lock_idx;
  logic              r_valid;
  logic [W-1:0]      r_data;
  logic              r_last;
  logic [L-1:0]      r_src;

  logic              w_load_en;
  logic [N-1:0]      w_req;
  logic              w_grant_valid;
  logic [L-1:0]      w_grant_idx;
  logic [W-1:0]      w_mux_data;
  logic [N-1:0][0:0] w_last_vec;
  logic [0:0]        w_mux_last;
  logic              w_xfer;

  // Output stage can take a new flit when empty or draining this cycle.
  assign w_load_en = !r_valid || o_ready;

  // While locked only the owning requester is visible to the picker, so a
  // paused owner stalls the arbiter instead of letting others interleave.
  always_comb begin
    w_req = '0;
    if (r_state == LOCKED) begin
      w_req[r_lock_idx] = i_valid[r_lock_idx];
    end else begin
      w_req = i_valid;
    end
  end

  rr_priority_pick #(
    .N (N)
  ) u_pick (
    .i_ptr         (r_ptr),
    .i_req         (w_req),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  generic_mux #(
    .N (N),
    .W (W)
  ) u_data_mux (
    .i_data (i_data),
    .i_sel  (w_grant_idx),
    .o_data (w_mux_data)
  );

  assign w_last_vec = i_last;

  generic_mux #(
    .N (N),
    .W (1)
  ) u_last_mux (
    .i_data (w_last_vec),
    .i_sel  (w_grant_idx),
    .o_data (w_mux_last)
  );

  for (genvar k = 0; k < N; k++) begin : g_ready
    assign i_ready[k] = w_load_en && w_grant_valid && (w_grant_idx == L'(k));
  end

  // A granted requester is valid by construction, so grant plus room is a
  // transfer.
  assign w_xfer = w_load_en && w_grant_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= UNLOCKED;
      r_ptr      <= L'(N - 1);
      r_lock_idx <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_src      <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_mux_data;
      r_last  <= w_mux_last[0];
      r_src   <= w_grant_idx;
      r_ptr   <= w_grant_idx;
      if (w_mux_last[0]) begin
        r_state <= UNLOCKED;
      end else begin
        r_state    <= LOCKED;
        r_lock_idx <= w_grant_idx;
      end
    end else if (o_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_src   = r_src;

endmodule : mux4_rr_arbiter
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mux4_rr_arbiter                                            |
// | Purpose  : Randomized scoreboard bench for mux4_rr_arbiter.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mux4_rr_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        i_valid;
  logic [N-1:0][W-1:0] i_data;
  logic [N-1:0]        i_last;
  logic [N-1:0]        i_ready;
  logic                o_valid;
  logic [W-1:0]        o_data;
  logic                o_last;
  logic [L-1:0]        o_src;
  logic                o_ready;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_src   (o_src),
    .o_ready (o_ready)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           src;
  } flit_t;

  flit_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (arbitration rules) ----------------
  int m_ptr;
  int m_lock;
  bit m_locked;
  bit m_ov;
  bit acc[N];

  task automatic model_reset();
    m_ptr    = N - 1;
    m_lock   = 0;
    m_locked = 1'b0;
    m_ov     = 1'b0;
    for (int k = 0; k < N; k++) acc[k] = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit           room;
    int           g;
    logic [N-1:0] exp_rdy;
    flit_t        f;
    room = !m_ov || o_ready;
    g    = -1;
    if (m_locked) begin
      if (i_valid[m_lock]) g = m_lock;
    end else begin
      for (int i = 1; i <= N; i++) begin
        if (g < 0 && i_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      end
    end
    exp_rdy = '0;
    if (room && g >= 0) exp_rdy[g] = 1'b1;
    chk("i_ready", i_ready, exp_rdy);
    if (room && g >= 0) begin
      f.data = i_data[g];
      f.last = i_last[g];
      f.src  = g;
      exp_q.push_back(f);
      m_ptr    = g;
      m_locked = !i_last[g];
      m_lock   = g;
      m_ov     = 1'b1;
      acc[g]   = 1'b1;
    end else if (o_ready) begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) model_step();
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_valid", o_valid, exp_q.size() != 0);
      if (o_valid && exp_q.size() != 0) begin
        chk("o_data", o_data, exp_q[0].data);
        chk("o_last", o_last, exp_q[0].last);
        chk("o_src",  o_src,  exp_q[0].src);
        if (o_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- requester / sink driver ----------------
  bit           v[N];
  bit           lst[N];
  bit           held[N];
  bit           started[N];
  int           rem[N];
  logic [W-1:0] dat[N];
  int           start_pct;
  int           maxlen;
  int           drop_pct;
  int           ready_pct;
  logic [N-1:0] mask;

  task automatic drv_reset();
    for (int k = 0; k < N; k++) begin
      v[k] = 0; lst[k] = 0; held[k] = 0; started[k] = 0; rem[k] = 0; dat[k] = '0;
    end
    i_valid = '0;
    i_data  = '0;
    i_last  = '0;
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        acc[k] = 1'b0;
        rem[k]--;
        if (rem[k] == 0) begin
          v[k] = 0;
          started[k] = 0;
        end else begin
          started[k] = 1;
          dat[k] = W'($urandom());
          lst[k] = (rem[k] == 1);
        end
      end else if (v[k]) begin
        // Only a requester part-way through a packet (the lock owner) pauses.
        if (started[k] && $urandom_range(0, 99) < drop_pct) begin
          v[k] = 0;
          held[k] = 1;
        end
      end else if (held[k]) begin
        if (drop_pct == 0 || $urandom_range(0, 1) == 1) begin
          v[k] = 1;
          held[k] = 0;
        end
      end else if (mask[k] && $urandom_range(0, 99) < start_pct) begin
        rem[k] = $urandom_range(1, maxlen);
        dat[k] = W'($urandom());
        lst[k] = (rem[k] == 1);
        v[k]   = 1;
      end
      i_valid[k] = v[k];
      i_data[k]  = dat[k];
      i_last[k]  = lst[k];
    end
    o_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) drive_cycle();
  endtask

  initial begin
    bit got_lock;
    rst_n   = 1'b0;
    o_ready = 1'b0;
    mask    = '1;
    start_pct = 0; maxlen = 1; drop_pct = 0; ready_pct = 100;
    drv_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_o_data", o_data, 0);
    chk("reset_o_last", o_last, 0);
    chk("reset_o_src",  o_src,  0);
    chk("reset_i_ready", i_ready, 0);

    // All requesters valid with single-flit packets: 0,1,2,3,0,...
    start_pct = 100; maxlen = 1; drop_pct = 0; ready_pct = 100; mask = 4'b1111;
    drive_cycle();
    @(negedge clk);
    chk("first_grant_req0", i_ready, 4'b0001);
    run(20);

    // Random multi-flit traffic with pauses and backpressure
    start_pct = 40; maxlen = 4; drop_pct = 15; ready_pct = 70;
    run(800);

    // Hard backpressure burst then release
    ready_pct = 0;
    run(5);
    ready_pct = 100;
    run(300);

    // Async reset while a packet holds the lock
    start_pct = 60; maxlen = 4; drop_pct = 0; ready_pct = 100;
    got_lock = 1'b0;
    for (int c = 0; c < 300 && !got_lock; c++) begin
      drive_cycle();
      if (m_locked) got_lock = 1'b1;
    end
    chk("lock_reached", got_lock, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_o_valid", o_valid, 0);
    chk("async_rst_o_data",  o_data,  0);
    chk("async_rst_o_src",   o_src,   0);
    model_reset();
    drv_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    start_pct = 100; maxlen = 1; drop_pct = 0; ready_pct = 100; mask = 4'b1110;
    drive_cycle();
    @(negedge clk);
    chk("first_grant_after_reset", i_ready, 4'b0010);
    run(20);

    // Random again, then drain
    mask = 4'b1111; start_pct = 50; maxlen = 3; drop_pct = 20; ready_pct = 60;
    run(600);
    start_pct = 0; drop_pct = 0; ready_pct = 100;
    run(40);
    @(negedge clk);
    #3;
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_o_valid", o_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux4_rr_arbiter
`default_nettype wire
